// File: rtl/cordic_atan2_front_pkg.sv
// cordic_atan2_front_pkg: shared encodings and default widths for the CORDIC atan2 front end
package cordic_atan2_front_pkg;
  localparam int CORDIC_IW = 16;
  localparam int CORDIC_DW = 32;
  typedef enum logic [1:0] {QUAD_NONE = 2'd0, QUAD_ADD_PI = 2'd1, QUAD_SUB_PI = 2'd2} quad_e;
  typedef enum logic [1:0] {IDLE, FOLD, NORM, OUT} state_e;
endpackage

// File: rtl/cordic_in_fifo.sv
// cordic_in_fifo: synchronous FIFO with registered full (ready) and empty flags
module cordic_in_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         empty,
  output logic [W-1:0] pop_data
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic rdy_q, rdy_d, empty_q, empty_d, push, pop_ok;
  assign push = push_valid && rdy_q;
  assign pop_ok = pop && !empty_q;
  assign push_ready = rdy_q;
  assign empty = empty_q;
  assign pop_data = mem_q[rd_q];
  always_comb begin
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop_ok ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop_ok);
    empty_d = cnt_d == '0;
    rdy_d = cnt_d != (AW+1)'(DEPTH);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      empty_q <= 1'b1;
      rdy_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      empty_q <= empty_d;
      rdy_q <= rdy_d;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wr_q] <= push_data;
endmodule

// File: rtl/cordic_atan2_front.sv
// cordic_atan2_front: buffers (x,y), folds into the right half-plane and normalises for the CORDIC core.
// Define CORDIC_NORM_EN to include the normalising shifter; without it outputs are the folded operands.
module cordic_atan2_front
  import cordic_atan2_front_pkg::*;
#(
  parameter int IW = CORDIC_IW,
  parameter int DW = CORDIC_DW,
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] x_in,
  input  logic [IW-1:0] y_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] x_out,
  output logic [DW-1:0] y_out,
  output logic [1:0]    quad,
  output logic [5:0]    shamt,
  output logic          zero_flag
);
  logic [2*IW-1:0] head;
  logic empty, pop, neg;
  state_e state_q, state_d;
  quad_e quad_q, quad_d;
  logic [DW-1:0] x_q, x_d, y_q, y_d;
  logic zero_q, zero_d, out_valid_q, out_valid_d;
  cordic_in_fifo #(.W(2*IW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push_valid(in_valid),
    .push_ready(in_ready),
    .push_data({x_in, y_in}),
    .pop(pop),
    .empty(empty),
    .pop_data(head)
  );
  assign pop = state_q == IDLE && !empty;
  assign neg = x_q[DW-1];
  assign x_out = x_q;
  assign y_out = y_q;
  assign quad = quad_q;
  assign zero_flag = zero_q;
  assign out_valid = out_valid_q;
`ifdef CORDIC_NORM_EN
  logic [5:0] shamt_q, shamt_d;
  logic norm_go;
  // keep shifting while x has headroom and y's top three bits are pure sign
  assign norm_go = x_q[DW-2:DW-3] == 2'b00 && (y_q[DW-1:DW-3] == 3'b000 || y_q[DW-1:DW-3] == 3'b111);
  assign shamt = shamt_q;
  always_comb shamt_d = pop ? 6'd0 : (state_q == NORM && norm_go) ? shamt_q + 6'd1 : shamt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shamt_q <= '0;
    else shamt_q <= shamt_d;
  end
`else
  assign shamt = 6'd0;
`endif
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    quad_d = quad_q;
    zero_d = zero_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: if (!empty) begin
        x_d = {{(DW-IW){head[2*IW-1]}}, head[2*IW-1:IW]};
        y_d = {{(DW-IW){head[IW-1]}}, head[IW-1:0]};
        quad_d = QUAD_NONE;
        zero_d = 1'b0;
        state_d = FOLD;
      end
      FOLD: begin
        x_d = neg ? -x_q : x_q;
        y_d = neg ? -y_q : y_q;
        quad_d = !neg ? QUAD_NONE : (y_q[DW-1] ? QUAD_SUB_PI : QUAD_ADD_PI);
        zero_d = x_q == '0 && y_q == '0;
`ifdef CORDIC_NORM_EN
        state_d = zero_d ? OUT : NORM;
`else
        state_d = OUT;
`endif
      end
`ifdef CORDIC_NORM_EN
      NORM: if (norm_go) begin
        x_d = {x_q[DW-2:0], 1'b0};
        y_d = {y_q[DW-2:0], 1'b0};
      end else begin
        out_valid_d = 1'b1;
        state_d = OUT;
      end
`endif
      OUT: begin
        out_valid_d = !(out_valid_q && out_ready);
        state_d = (out_valid_q && out_ready) ? IDLE : OUT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      quad_q <= QUAD_NONE;
      zero_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      quad_q <= quad_d;
      zero_q <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_cordic_atan2_front.sv
// tb_cordic_atan2_front: directed and random vectors against an arithmetic reference model
module tb_cordic_atan2_front;
  localparam int IW = 16;
  localparam int DW = 32;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, zero_flag;
  logic [IW-1:0] x_in = '0, y_in = '0;
  logic [DW-1:0] x_out, y_out;
  logic [1:0] quad;
  logic [5:0] shamt;
  int passed = 0, failed = 0, total = 0;
  typedef struct {longint x; longint y; int q; int s; int z; int lat;} exp_t;
  cordic_atan2_front #(.IW(IW), .DW(DW), .FIFO_DEPTH(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .x_in(x_in),
    .y_in(y_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x_out(x_out),
    .y_out(y_out),
    .quad(quad),
    .shamt(shamt),
    .zero_flag(zero_flag)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input int xi, input int yi);
    exp_t e;
    longint x = xi, y = yi, lim = 64'sd1 <<< (DW - 3);
    e.q = 0;
    e.s = 0;
    e.z = (xi == 0 && yi == 0) ? 1 : 0;
    if (x < 0) begin
      x = -x;
      y = -y;
      e.q = (yi >= 0) ? 1 : 2;
    end
`ifdef CORDIC_NORM_EN
    if (e.z == 0)
      while (x < lim && y >= -lim && y < lim) begin
        x = x * 2;
        y = y * 2;
        e.s++;
      end
`endif
    e.x = x;
    e.y = y;
    e.lat = e.s + 3;
    lim = 0;
    return e;
  endfunction
  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, "/x_out"}, longint'($signed(x_out)), e.x);
    chk({tag, "/y_out"}, longint'($signed(y_out)), e.y);
    chk({tag, "/quad"}, quad, e.q);
    chk({tag, "/shamt"}, shamt, e.s);
    chk({tag, "/zero"}, zero_flag, e.z);
  endtask
  task automatic run_vec(input int xi, input int yi, input string tag);
    exp_t e;
    int lat, n;
    e = model(xi, yi);
    n = 0;
    while (!in_ready && n < 100) begin step(); n++; end
    chk({tag, "/in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    x_in = IW'(xi);
    y_in = IW'(yi);
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin step(); lat++; end
    chk({tag, "/latency"}, lat, e.lat);
    chk_out(tag, e);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "/drop"}, out_valid, 0);
  endtask
  initial begin
    int vx[4], vy[4];
    int n, got;
    logic acc, seen;
    exp_t e;
    vx = '{300, -7, 0, -32768};
    vy = '{-20, 9, 1, 32767};
    #2;
    chk("rst/out_valid", out_valid, 0);
    chk("rst/in_ready", in_ready, 0);
    chk("rst/x_out", x_out, 0);
    chk("rst/quad", quad, 0);
    chk("rst/shamt", shamt, 0);
    #10 rst_n = 1'b1;
    step();
    chk("rst/in_ready_rise", in_ready, 1);
    run_vec(1000, 0, "d1000_0");
    run_vec(-100, 50, "dm100_50");
    run_vec(-32768, -1, "dm32768_m1");
    run_vec(0, 0, "dzero");
    run_vec(0, 5, "d0_5");
    run_vec(0, -7, "d0_m7");
    run_vec(32767, -32768, "dmaxmin");
    run_vec(-32768, 0, "dm32768_0");
    run_vec(-1, -1, "dm1_m1");
    run_vec(1, 0, "d1_0");
    for (int i = 0; i < 16; i++) begin
      logic signed [IW-1:0] rx, ry;
      rx = IW'($urandom);
      ry = IW'($urandom);
      rx = rx >>> $urandom_range(0, 15);
      ry = ry >>> $urandom_range(0, 15);
      run_vec(int'(rx), int'(ry), $sformatf("rnd%0d", i));
    end
    // four vectors pushed while the core refuses output
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall/in_ready%0d", i), in_ready, 1);
      in_valid = 1'b1;
      x_in = IW'(vx[i]);
      y_in = IW'(vy[i]);
      step();
    end
    x_in = IW'(vx[3]);
    y_in = IW'(vy[3]);
    chk("stall/full", in_ready, 0);
    n = 0;
    while (!out_valid && n < 200) begin step(); n++; end
    chk("stall/out_valid", out_valid, 1);
    e = model(vx[0], vy[0]);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("stall/hold%0d", i), e);
      chk($sformatf("stall/held_in%0d", i), in_ready, 0);
    end
    out_ready = 1'b1;
    got = 0;
    n = 0;
    while (got < 4 && n < 500) begin
      if (out_valid) begin
        chk_out($sformatf("stall/order%0d", got), model(vx[got], vy[got]));
        got++;
      end
      acc = in_valid && in_ready;
      step();
      n++;
      if (acc) in_valid = 1'b0;
    end
    chk("stall/count", got, 4);
    out_ready = 1'b0;
    in_valid = 1'b0;
    step();
    // reset while busy with a second vector still buffered
    in_valid = 1'b1;
    x_in = IW'(1000);
    y_in = '0;
    step();
    x_in = IW'(5);
    y_in = IW'(5);
    step();
    in_valid = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst/out_valid", out_valid, 0);
    chk("arst/in_ready", in_ready, 0);
    chk("arst/x_out", x_out, 0);
    step();
    #1 rst_n = 1'b1;
    step();
    chk("arst/in_ready_rise", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen = seen | out_valid;
      step();
    end
    chk("arst/discarded", seen, 0);
    run_vec(1000, 0, "post_rst");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
